// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode-class helpers for the
// sequential ALU and any decoder that needs to classify operations.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Operations handled by the iterative multiply/divide unit.
    function automatic logic is_iter_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Division-class operations (quotient or remainder).
    function automatic logic is_div_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_DIVU, OP_REMU: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) unit.
// One iteration per clock; done_o is high during the last iteration and
// result_o then carries the final value, to be captured on that edge.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    // hi_q: product high half (MUL) or partial remainder (DIV)
    // lo_q: multiplier / product low half (MUL) or dividend / quotient (DIV)
    // opnd_q: multiplicand (MUL) or divisor (DIV)
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [3:0]       op_q;

    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH:0]   diff_s;
    logic             ge_s;
    logic             last_s;

    assign last_s = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign done_o = last_s;

    // One shift-add or restoring-subtract step, plus result selection.
    always_comb begin
        add_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        shl_s  = {hi_q, lo_q[WIDTH-1]};
        diff_s = shl_s - {1'b0, opnd_q};
        ge_s   = (shl_s >= {1'b0, opnd_q});
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (is_div_op(op_q)) begin
            hi_d = ge_s ? diff_s[WIDTH-1:0] : shl_s[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge_s};
        end else begin
            hi_d = add_s[WIDTH:1];
            lo_d = {add_s[0], lo_q[WIDTH-1:1]};
        end
        case (op_q)
            OP_MUL:   result_o = lo_d;
            OP_MULHU: result_o = hi_d;
            OP_DIVU:  result_o = lo_d;
            OP_REMU:  result_o = hi_d;
            default:  result_o = {WIDTH{1'b0}};
        endcase
    end

    // Operand load on start, then WIDTH iterations while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            opnd_q <= {WIDTH{1'b0}};
            op_q   <= 4'b0000;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= {CNT_W{1'b0}};
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= is_div_op(op_i) ? a_i : b_i;
            opnd_q <= is_div_op(op_i) ? b_i : a_i;
            op_q   <= op_i;
        end else if (busy_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (last_s) begin
                busy_q <= 1'b0;
                cnt_q  <= {CNT_W{1'b0}};
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake. Add/sub/logic/compare finish in
// one cycle; multiply/divide run through the iterative sub-unit. Result and
// flags are registered and held until the consumer takes them.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q, n_q, c_q, v_q;

    logic [WIDTH-1:0] b_eff_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic             carry_s;
    logic             ovf_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic             div0_s;
    logic             start_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_res_s;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign z         = z_q;
    assign n         = n_q;
    assign c         = c_q;
    assign v         = v_q;

    // Single-cycle datapath: shared adder, logic ops and divide-by-zero results.
    always_comb begin
        if (op == OP_ADD) begin
            b_eff_s = b;
            cin_s   = 1'b0;
        end else begin
            b_eff_s = ~b;
            cin_s   = 1'b1;
        end
        sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
        carry_s = sum_s[WIDTH];
        ovf_s   = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        div0_s  = is_div_op(op) && (b == {WIDTH{1'b0}});
        start_s = (state_q == ST_IDLE) && in_valid && is_iter_op(op) && !div0_s;
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = carry_s;
                alu_v_s   = ovf_s;
            end
            OP_SLT: begin
                alu_res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
                alu_c_s   = carry_s;
                alu_v_s   = ovf_s;
            end
            OP_SLTU: begin
                alu_res_s = {{(WIDTH-1){1'b0}}, ~carry_s};
                alu_c_s   = carry_s;
            end
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_DIVU: alu_res_s = {WIDTH{1'b1}};
            OP_REMU: alu_res_s = a;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_s),
        .a_i      (a),
        .b_i      (b),
        .op_i     (op),
        .done_o   (md_done_s),
        .result_o (md_res_s)
    );

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (start_s) begin
                            state_q <= ST_CALC;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res_s;
                            z_q         <= (alu_res_s == {WIDTH{1'b0}});
                            n_q         <= alu_res_s[WIDTH-1];
                            c_q         <= alu_c_s;
                            v_q         <= alu_v_s;
                        end
                    end
                end
                ST_CALC: begin
                    if (md_done_s) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_res_s;
                        z_q         <= (md_res_s == {WIDTH{1'b0}});
                        n_q         <= md_res_s[WIDTH-1];
                        c_q         <= 1'b0;
                        v_q         <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): table of vectors with expected
// result/flags/latency fed through a scoreboard queue, plus hold and
// mid-operation reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        z, n, c, v;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;   // {z,n,c,v}
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    vec_t vtab [26];
    exp_t sb_q [$];

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation, wait for its result, compare against the scoreboard,
    // optionally hold it in DONE for 'hold' cycles, then consume it.
    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] eres,
                          input logic [3:0] eflg, input int elat, input int hold);
        exp_t e;
        int   lat;
        op = o; a = va; b = vb; in_valid = 1'b1;
        chk({name, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        e.res = eres; e.flg = eflg; e.lat = elat;
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        if (!out_valid) begin
            chk({name, ".timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, ".result"}, {32'd0, result}, {32'd0, e.res});
            chk({name, ".flags"}, {60'd0, z, n, c, v}, {60'd0, e.flg});
            chk({name, ".latency"}, 64'(lat), 64'(e.lat));
            for (int i = 0; i < hold; i++) begin
                a = ~a;
                @(posedge clk); #1;
                chk({name, ".hold_result"}, {32'd0, result}, {32'd0, e.res});
                chk({name, ".hold_flags"}, {60'd0, z, n, c, v}, {60'd0, e.flg});
                chk({name, ".hold_in_ready"}, {63'd0, in_ready}, 64'd0);
                chk({name, ".hold_out_valid"}, {63'd0, out_valid}, 64'd1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, ".release_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({name, ".release_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int          seen;
        logic [31:0] res_at_rst;
        vtab[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1};
        vtab[1]  = '{OP_SLT,   32'h80000000, 32'h00000001, 32'h00000001, 4'b0011, 1};
        vtab[2]  = '{OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 4'b1010, 1};
        vtab[3]  = '{OP_SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0100, 1};
        vtab[4]  = '{OP_SLTU,  32'h00000003, 32'h00000005, 32'h00000001, 4'b0000, 1};
        vtab[5]  = '{OP_SLTU,  32'h00000005, 32'h00000003, 32'h00000000, 4'b1010, 1};
        vtab[6]  = '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1};
        vtab[7]  = '{OP_OR,    32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1};
        vtab[8]  = '{OP_XOR,   32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b1000, 1};
        vtab[9]  = '{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1};
        vtab[10] = '{4'b0111,  32'h12345678, 32'h00000009, 32'h00000000, 4'b1000, 1};
        vtab[11] = '{4'b1111,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 1};
        vtab[12] = '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 33};
        vtab[13] = '{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 33};
        vtab[14] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000, 33};
        vtab[15] = '{OP_REMU,  32'h00000064, 32'h00000007, 32'h00000002, 4'b0000, 33};
        vtab[16] = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 1};
        vtab[17] = '{OP_REMU,  32'h00001234, 32'h00000000, 32'h00001234, 4'b0000, 1};
        vtab[18] = '{OP_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 4'b1000, 33};
        vtab[19] = '{OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 4'b0000, 33};
        vtab[20] = '{OP_DIVU,  32'h00000003, 32'h00000005, 32'h00000000, 4'b1000, 33};
        vtab[21] = '{OP_REMU,  32'h00000003, 32'h00000005, 32'h00000003, 4'b0000, 33};
        vtab[22] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 4'b0100, 33};
        vtab[23] = '{OP_SLT,   32'h00000005, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 1};
        vtab[24] = '{OP_SLT,   32'hFFFFFFFF, 32'h00000005, 32'h00000001, 4'b0010, 1};
        vtab[25] = '{OP_MUL,   32'h00001234, 32'h00000100, 32'h00123400, 4'b0000, 33};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; op = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset.result", {32'd0, result}, 64'd0);
        chk("reset.flags", {60'd0, z, n, c, v}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset.in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 26; i++) begin
            run_op($sformatf("vec%0d", i), vtab[i].op, vtab[i].a, vtab[i].b,
                   vtab[i].res, vtab[i].flg, vtab[i].lat, 0);
        end

        // Consumer stalls for 5 cycles while operand A toggles.
        run_op("hold_add", OP_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 1, 5);

        // Reset 10 cycles into a divide: the operation must vanish.
        op = OP_DIVU; a = 32'h00000064; b = 32'h00000007; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("rstdiv.busy_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        #1;
        res_at_rst = result;
        chk("rstdiv.async_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstdiv.async_result", {32'd0, res_at_rst}, 64'd0);
        chk("rstdiv.async_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rstdiv.no_out_valid", 64'(seen), 64'd0);
        chk("rstdiv.in_ready", {63'd0, in_ready}, 64'd1);
        run_op("rstdiv.add", OP_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
